// File: rtl/laser_pkg.sv
// Shared constants, FSM state type and the restoring-divide step for laser_locator.
package laser_pkg;

    localparam int CAM_W    = 1280;
    localparam int CAM_H    = 960;
    localparam int COORD_W  = 11;
    localparam int SUM_W    = 32;
    localparam int CNT_W    = 21;
    localparam int X_CENTRE = 640;
    localparam int Y_CENTRE = 480;

    typedef enum logic [1:0] {
        IDLE,
        DIV_X,
        DIV_Y,
        UPDATE
    } laser_state_t;

    typedef struct packed {
        logic [SUM_W-1:0] rem;
        logic [SUM_W-1:0] quo;
    } div_step_t;

    // One restoring step: the partial remainder stays below the divisor, so the
    // shifted value needs one extra bit; a zero divisor yields all-ones.
    function automatic div_step_t div_step(input logic [SUM_W-1:0] rem,
                                           input logic [SUM_W-1:0] quo,
                                           input logic [SUM_W-1:0] div);
        div_step_t      res;
        logic [SUM_W:0] shifted;
        shifted = {rem, quo[SUM_W-1]};
        if (shifted >= {1'b0, div}) begin
            res.rem = SUM_W'(shifted - {1'b0, div});
            res.quo = {quo[SUM_W-2:0], 1'b1};
        end else begin
            res.rem = shifted[SUM_W-1:0];
            res.quo = {quo[SUM_W-2:0], 1'b0};
        end
        return res;
    endfunction

endpackage

// File: rtl/laser_locator_if.sv
// Pixel-stream and centroid-result bundle between the camera side and laser_locator.
interface laser_locator_if #(
    parameter int PIX_W = 8
);
    import laser_pkg::*;

    logic                 Pix_Valid;
    logic [PIX_W-1:0]     Pix_R;
    logic [PIX_W-1:0]     Pix_G;
    logic [PIX_W-1:0]     Pix_B;
    logic [COORD_W-1:0]   Pix_X;
    logic [COORD_W-1:0]   Pix_Y;
    logic                 Frame_Done;
    logic [COORD_W-1:0]   xLaser;
    logic [COORD_W-1:0]   yLaser;
    logic                 Laser_Found;
    logic                 Coord_Valid;
    logic                 Busy;
    logic                 Overrun;

    modport master (
        output Pix_Valid, Pix_R, Pix_G, Pix_B, Pix_X, Pix_Y, Frame_Done,
        input  xLaser, yLaser, Laser_Found, Coord_Valid, Busy, Overrun
    );

    modport slave (
        input  Pix_Valid, Pix_R, Pix_G, Pix_B, Pix_X, Pix_Y, Frame_Done,
        output xLaser, yLaser, Laser_Found, Coord_Valid, Busy, Overrun
    );

endinterface

// File: rtl/seq_divider.sv
// 32-bit restoring divider, one quotient bit per cycle; the first bit is
// resolved on the start edge so done pulses 32 cycles after start.
module seq_divider
    import laser_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [SUM_W-1:0] divisor,
    output logic [SUM_W-1:0] quotient,
    output logic             done
);

    logic [SUM_W-1:0] rem_q, rem_d;
    logic [SUM_W-1:0] quo_q, quo_d;
    logic [SUM_W-1:0] div_q, div_d;
    logic [4:0]       count_q, count_d;
    logic             done_q, done_d;
    div_step_t        step;

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        count_d = count_q;
        done_d  = 1'b0;
        step    = '0;
        if (start) begin
            step    = div_step('0, dividend, divisor);
            rem_d   = step.rem;
            quo_d   = step.quo;
            div_d   = divisor;
            count_d = 5'd31;
        end else if (count_q != 5'd0) begin
            step    = div_step(rem_q, quo_q, div_q);
            rem_d   = step.rem;
            quo_d   = step.quo;
            count_d = count_q - 5'd1;
            done_d  = (count_q == 5'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/laser_locator.sv
// Bright-red pixel centroid finder: accumulates per frame, divides X then Y.
// Define LASER_HOLD_EN to keep the previous coordinates on frames without a detection.
module laser_locator
    import laser_pkg::*;
#(
    parameter int PIX_W      = 8,
    parameter int R_THRESH   = 200,
    parameter int GB_MAX     = 120,
    parameter int MIN_PIXELS = 4,
    parameter int X_MAX      = CAM_W - 1,
    parameter int Y_MAX      = CAM_H - 1
) (
    input  logic            Clk,
    input  logic            Reset_N,
    laser_locator_if.slave  bus
);

    laser_state_t       state_q, state_d;
    logic [SUM_W-1:0]   sum_x_q, sum_x_d;
    logic [SUM_W-1:0]   sum_y_q, sum_y_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SUM_W-1:0]   snap_y_q, snap_y_d;
    logic [CNT_W-1:0]   snap_cnt_q, snap_cnt_d;
    logic [SUM_W-1:0]   qx_q, qx_d;
    logic [COORD_W-1:0] x_laser_q, x_laser_d;
    logic [COORD_W-1:0] y_laser_q, y_laser_d;
    logic               found_q, found_d;
    logic               coord_valid_q, coord_valid_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;

    logic               qualify;
    logic [SUM_W-1:0]   sum_x_acc, sum_y_acc;
    logic [CNT_W-1:0]   cnt_acc;
    logic               div_start, div_done;
    logic [SUM_W-1:0]   div_dividend, div_divisor, div_quotient;

    seq_divider u_div (
        .clk      (Clk),
        .rst_n    (Reset_N),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quotient),
        .done     (div_done)
    );

    always_comb begin
        qualify = bus.Pix_Valid
               && (bus.Pix_R >= PIX_W'(R_THRESH))
               && (bus.Pix_G <= PIX_W'(GB_MAX))
               && (bus.Pix_B <= PIX_W'(GB_MAX));
        sum_x_acc = sum_x_q + (qualify ? SUM_W'(bus.Pix_X) : '0);
        sum_y_acc = sum_y_q + (qualify ? SUM_W'(bus.Pix_Y) : '0);
        cnt_acc   = (qualify && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

        state_d       = state_q;
        sum_x_d       = sum_x_acc;
        sum_y_d       = sum_y_acc;
        cnt_d         = cnt_acc;
        snap_y_d      = snap_y_q;
        snap_cnt_d    = snap_cnt_q;
        qx_d          = qx_q;
        x_laser_d     = x_laser_q;
        y_laser_d     = y_laser_q;
        found_d       = found_q;
        coord_valid_d = 1'b0;
        busy_d        = (state_q != IDLE);
        overrun_d     = overrun_q;
        div_start     = 1'b0;
        div_dividend  = '0;
        div_divisor   = '0;

        // The pixel arriving with Frame_Done belongs to the ending frame, so the
        // snapshot takes the post-accumulation values while the sums restart at zero.
        if (bus.Frame_Done) begin
            sum_x_d = '0;
            sum_y_d = '0;
            cnt_d   = '0;
            if (state_q == IDLE) begin
                snap_y_d     = sum_y_acc;
                snap_cnt_d   = cnt_acc;
                div_start    = 1'b1;
                div_dividend = sum_x_acc;
                div_divisor  = SUM_W'(cnt_acc);
                state_d      = DIV_X;
            end else begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            DIV_X: begin
                if (div_done) begin
                    qx_d         = div_quotient;
                    div_start    = 1'b1;
                    div_dividend = snap_y_q;
                    div_divisor  = SUM_W'(snap_cnt_q);
                    state_d      = DIV_Y;
                end
            end
            DIV_Y: begin
                if (div_done) state_d = UPDATE;
            end
            UPDATE: begin
                coord_valid_d = 1'b1;
                state_d       = IDLE;
                if (snap_cnt_q >= CNT_W'(MIN_PIXELS)) begin
                    found_d   = 1'b1;
                    x_laser_d = (qx_q > SUM_W'(X_MAX)) ? COORD_W'(X_MAX) : qx_q[COORD_W-1:0];
                    y_laser_d = (div_quotient > SUM_W'(Y_MAX)) ? COORD_W'(Y_MAX)
                                                               : div_quotient[COORD_W-1:0];
                end else begin
                    found_d = 1'b0;
`ifdef LASER_HOLD_EN
                    x_laser_d = x_laser_q;
                    y_laser_d = y_laser_q;
`else
                    x_laser_d = COORD_W'(X_CENTRE);
                    y_laser_d = COORD_W'(Y_CENTRE);
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q       <= IDLE;
            sum_x_q       <= '0;
            sum_y_q       <= '0;
            cnt_q         <= '0;
            snap_y_q      <= '0;
            snap_cnt_q    <= '0;
            qx_q          <= '0;
            x_laser_q     <= COORD_W'(X_CENTRE);
            y_laser_q     <= COORD_W'(Y_CENTRE);
            found_q       <= 1'b0;
            coord_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sum_x_q       <= sum_x_d;
            sum_y_q       <= sum_y_d;
            cnt_q         <= cnt_d;
            snap_y_q      <= snap_y_d;
            snap_cnt_q    <= snap_cnt_d;
            qx_q          <= qx_d;
            x_laser_q     <= x_laser_d;
            y_laser_q     <= y_laser_d;
            found_q       <= found_d;
            coord_valid_q <= coord_valid_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
        end
    end

    assign bus.xLaser      = x_laser_q;
    assign bus.yLaser      = y_laser_q;
    assign bus.Laser_Found = found_q;
    assign bus.Coord_Valid = coord_valid_q;
    assign bus.Busy        = busy_q;
    assign bus.Overrun     = overrun_q;

endmodule

// File: tb/tb_laser_locator.sv
// Directed self-checking bench for laser_locator: centroid, colour thresholds,
// minimum count, clipping, overrun, reset mid-division and end-of-frame pixel.
module tb_laser_locator;

    logic Clk = 1'b0;
    logic Reset_N = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    laser_locator_if #(.PIX_W(8)) bus ();

    laser_locator dut (
        .Clk     (Clk),
        .Reset_N (Reset_N),
        .bus     (bus)
    );

    task automatic stepClock();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic setPixel(input logic valid, input int x, input int y,
                            input int r, input int g, input int b);
        bus.Pix_Valid = valid;
        bus.Pix_X     = 11'(x);
        bus.Pix_Y     = 11'(y);
        bus.Pix_R     = 8'(r);
        bus.Pix_G     = 8'(g);
        bus.Pix_B     = 8'(b);
    endtask

    // Presents one pixel for a single clock edge.
    task automatic applyStimulus(input logic valid, input int x, input int y,
                                 input int r, input int g, input int b);
        setPixel(valid, x, y, r, g, b);
        stepClock();
        bus.Pix_Valid = 1'b0;
    endtask

    // Pulses Frame_Done (with whatever pixel is already on the bus) and checks
    // the fixed 66-cycle result timing and the delivered values.
    task automatic runFrame(input string tag, input int ex, input int ey, input logic ef);
        bus.Frame_Done = 1'b1;
        stepClock();
        bus.Frame_Done = 1'b0;
        bus.Pix_Valid  = 1'b0;
        checkOutput({tag, "_busy_n"}, 32'(bus.Busy), 32'd0);
        stepClock();
        checkOutput({tag, "_busy_n1"}, 32'(bus.Busy), 32'd1);
        for (int k = 2; k <= 64; k++) stepClock();
        checkOutput({tag, "_cv_early"}, 32'(bus.Coord_Valid), 32'd0);
        stepClock();
        checkOutput({tag, "_cv"}, 32'(bus.Coord_Valid), 32'd1);
        checkOutput({tag, "_x"}, 32'(bus.xLaser), 32'(ex));
        checkOutput({tag, "_y"}, 32'(bus.yLaser), 32'(ey));
        checkOutput({tag, "_found"}, 32'(bus.Laser_Found), 32'(ef));
        stepClock();
        checkOutput({tag, "_cv_pulse"}, 32'(bus.Coord_Valid), 32'd0);
        checkOutput({tag, "_busy_end"}, 32'(bus.Busy), 32'd0);
    endtask

    initial begin
        bit sawValid;
        setPixel(1'b0, 0, 0, 0, 0, 0);
        bus.Frame_Done = 1'b0;

        $display("[TB] reset state");
        stepClock();
        stepClock();
        checkOutput("rst_x", 32'(bus.xLaser), 32'd640);
        checkOutput("rst_y", 32'(bus.yLaser), 32'd480);
        checkOutput("rst_found", 32'(bus.Laser_Found), 32'd0);
        checkOutput("rst_cv", 32'(bus.Coord_Valid), 32'd0);
        checkOutput("rst_busy", 32'(bus.Busy), 32'd0);
        checkOutput("rst_overrun", 32'(bus.Overrun), 32'd0);
        Reset_N = 1'b1;
        stepClock();

        $display("[TB] 3x3 blob at (700,300)");
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                applyStimulus(1'b1, 700 + dx, 300 + dy, 255, 0, 0);
        runFrame("blob", 700, 300, 1'b1);

        $display("[TB] boundary colours, truncated centroid");
        applyStimulus(1'b1, 100, 200, 200, 120, 0);
        applyStimulus(1'b1, 110, 210, 255, 0, 120);
        applyStimulus(1'b1, 1000, 900, 199, 0, 0);
        applyStimulus(1'b1, 1000, 900, 255, 0, 121);
        applyStimulus(1'b1, 1000, 900, 255, 121, 0);
        applyStimulus(1'b0, 1000, 900, 255, 0, 0);
        applyStimulus(1'b1, 120, 220, 200, 120, 120);
        applyStimulus(1'b1, 131, 231, 255, 0, 0);
        runFrame("bound", 115, 215, 1'b1);

        $display("[TB] three pixels, below minimum");
        applyStimulus(1'b1, 10, 20, 255, 0, 0);
        applyStimulus(1'b1, 30, 40, 255, 0, 0);
        applyStimulus(1'b1, 50, 60, 255, 0, 0);
`ifdef LASER_HOLD_EN
        runFrame("few", 115, 215, 1'b0);
`else
        runFrame("few", 640, 480, 1'b0);
`endif

        $display("[TB] coordinates beyond camera space clip");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2000, 1000, 255, 0, 0);
        runFrame("clip", 1279, 959, 1'b1);

        $display("[TB] overrun");
        applyStimulus(1'b1, 400, 100, 255, 0, 0);
        applyStimulus(1'b1, 402, 100, 255, 0, 0);
        applyStimulus(1'b1, 400, 102, 255, 0, 0);
        applyStimulus(1'b1, 402, 102, 255, 0, 0);
        bus.Frame_Done = 1'b1;
        stepClock();
        bus.Frame_Done = 1'b0;
        applyStimulus(1'b1, 900, 900, 255, 0, 0);
        for (int k = 2; k <= 9; k++) stepClock();
        checkOutput("ovr_before", 32'(bus.Overrun), 32'd0);
        bus.Frame_Done = 1'b1;
        stepClock();
        bus.Frame_Done = 1'b0;
        checkOutput("ovr_set", 32'(bus.Overrun), 32'd1);
        applyStimulus(1'b1, 50, 50, 255, 0, 0);
        applyStimulus(1'b1, 52, 50, 255, 0, 0);
        applyStimulus(1'b1, 50, 52, 255, 0, 0);
        applyStimulus(1'b1, 52, 52, 255, 0, 0);
        for (int k = 15; k <= 64; k++) stepClock();
        checkOutput("ovr_cv_early", 32'(bus.Coord_Valid), 32'd0);
        stepClock();
        checkOutput("ovr_cv", 32'(bus.Coord_Valid), 32'd1);
        checkOutput("ovr_x", 32'(bus.xLaser), 32'd401);
        checkOutput("ovr_y", 32'(bus.yLaser), 32'd101);
        checkOutput("ovr_found", 32'(bus.Laser_Found), 32'd1);
        stepClock();
        runFrame("after_ovr", 51, 51, 1'b1);
        checkOutput("ovr_sticky", 32'(bus.Overrun), 32'd1);

        $display("[TB] reset during Y division");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 600, 600, 255, 0, 0);
        bus.Frame_Done = 1'b1;
        stepClock();
        bus.Frame_Done = 1'b0;
        for (int k = 1; k <= 40; k++) stepClock();
        checkOutput("abort_busy_pre", 32'(bus.Busy), 32'd1);
        Reset_N = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(bus.Busy), 32'd0);
        checkOutput("abort_x", 32'(bus.xLaser), 32'd640);
        checkOutput("abort_y", 32'(bus.yLaser), 32'd480);
        checkOutput("abort_found", 32'(bus.Laser_Found), 32'd0);
        checkOutput("abort_overrun", 32'(bus.Overrun), 32'd0);
        stepClock();
        stepClock();
        Reset_N = 1'b1;
        sawValid = 1'b0;
        for (int k = 0; k < 70; k++) begin
            stepClock();
            if (bus.Coord_Valid === 1'b1) sawValid = 1'b1;
        end
        checkOutput("abort_no_cv", 32'(sawValid), 32'd0);
        checkOutput("abort_x_hold", 32'(bus.xLaser), 32'd640);

        $display("[TB] corner pixel coincident with Frame_Done");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1279, 959, 255, 0, 0);
        setPixel(1'b1, 1279, 959, 255, 0, 0);
        runFrame("corner", 1279, 959, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
